// File: rtl/lock_access_ctrl_if.sv
// rtl/lock_access_ctrl_if.sv - keypad, password-update and status signal bundle for the lock controller
interface lock_access_ctrl_if #(
    parameter int DIGITS = 3
);
    logic                  digit_valid;
    logic [3:0]            digit;
    logic                  enter;
    logic                  clear;
    logic                  set_req;
    logic [4*DIGITS-1:0]   new_pass;
    logic                  access;
    logic                  alarm;
    logic                  lockout;
    logic [1:0]            fail_cnt;
    logic [1:0]            digit_cnt;
    logic                  pass_updated;

    modport master (
        output digit_valid, digit, enter, clear, set_req, new_pass,
        input  access, alarm, lockout, fail_cnt, digit_cnt, pass_updated
    );

    modport slave (
        input  digit_valid, digit, enter, clear, set_req, new_pass,
        output access, alarm, lockout, fail_cnt, digit_cnt, pass_updated
    );
endinterface

// File: rtl/lock_access_ctrl.sv
// rtl/lock_access_ctrl.sv - keypad entry/check/open/lockout FSM; ALARM_LATCH_EN keeps alarm set after lockout
module lock_access_ctrl #(
    parameter int          DIGITS       = 3,
    parameter int          MAX_FAIL     = 3,
    parameter int          OPEN_CYCLES  = 16,
    parameter int          LOCK_CYCLES  = 64,
    parameter logic [11:0] DEFAULT_PASS = 12'h000
) (
    input  logic                clk,
    input  logic                Reset,
    lock_access_ctrl_if.slave   bus
);
    localparam int PW = 4 * DIGITS;
    localparam int TW = $clog2(OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_OPEN,
        S_LOCKOUT
    } state_t;

    state_t          state;
    logic [PW-1:0]   entry_buf;
    logic [PW-1:0]   stored_pass;
    logic [TW-1:0]   timer;
    logic [1:0]      digit_cnt;
    logic [1:0]      fail_cnt;
    logic            access;
    logic            alarm;
    logic            lockout;
    logic            pass_updated;
    logic            match;

    // Short entries never match, even if the partial buffer happens to equal the password.
    assign match = (digit_cnt == 2'(DIGITS)) && (entry_buf == stored_pass);

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            entry_buf    <= '0;
            stored_pass  <= PW'(DEFAULT_PASS);
            timer        <= '0;
            digit_cnt    <= '0;
            fail_cnt     <= '0;
            access       <= 1'b0;
            alarm        <= 1'b0;
            lockout      <= 1'b0;
            pass_updated <= 1'b0;
        end else begin
            pass_updated <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (bus.clear) begin
                        entry_buf <= '0;
                        digit_cnt <= '0;
                        state     <= S_IDLE;
                    end else if (bus.enter) begin
                        state <= S_CHECK;
                    end else if (bus.digit_valid && (digit_cnt < 2'(DIGITS))) begin
                        entry_buf <= {entry_buf[PW-5:0], bus.digit};
                        digit_cnt <= digit_cnt + 2'd1;
                        state     <= S_ENTRY;
                    end
                end
                S_CHECK: begin
                    entry_buf <= '0;
                    digit_cnt <= '0;
                    if (match) begin
                        state    <= S_OPEN;
                        fail_cnt <= '0;
                        access   <= 1'b1;
                        timer    <= TW'(OPEN_CYCLES - 1);
                    end else if ((int'(fail_cnt) + 1) < MAX_FAIL) begin
                        state    <= S_IDLE;
                        fail_cnt <= fail_cnt + 2'd1;
                    end else begin
                        state    <= S_LOCKOUT;
                        fail_cnt <= 2'(MAX_FAIL);
                        alarm    <= 1'b1;
                        lockout  <= 1'b1;
                        timer    <= TW'(LOCK_CYCLES - 1);
                    end
                end
                S_OPEN: begin
                    // Password change and early relock are independent and may land together.
                    if (bus.set_req) begin
                        stored_pass  <= bus.new_pass;
                        pass_updated <= 1'b1;
                    end
                    if (bus.enter || (timer == '0)) begin
                        state  <= S_IDLE;
                        access <= 1'b0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= S_IDLE;
                        lockout  <= 1'b0;
                        fail_cnt <= '0;
`ifdef ALARM_LATCH_EN
                        alarm    <= 1'b1;
`else
                        alarm    <= 1'b0;
`endif
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.access       = access;
    assign bus.alarm        = alarm;
    assign bus.lockout      = lockout;
    assign bus.fail_cnt     = fail_cnt;
    assign bus.digit_cnt    = digit_cnt;
    assign bus.pass_updated = pass_updated;
endmodule

// File: tb/tb_lock_access_ctrl.sv
// tb/tb_lock_access_ctrl.sv - directed-vector bench for lock_access_ctrl
module tb_lock_access_ctrl;
    logic clk;
    logic Reset;
    int   passed;
    int   total;
    int   n;

    lock_access_ctrl_if #(.DIGITS(3)) bus ();

    lock_access_ctrl dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    // Enter, then the CHECK cycle; the result is visible on return.
    task automatic submit();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        check("check_state_access", 32'(bus.access), 32'd0);
        tick();
    endtask

    task automatic relock();
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        tick();
    endtask

    task automatic reset_dut();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Reset  = 1'b1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'h0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;
        bus.set_req     = 1'b0;
        bus.new_pass    = 12'h000;
        reset_dut();

        check("rst_access",    32'(bus.access),       32'd0);
        check("rst_alarm",     32'(bus.alarm),        32'd0);
        check("rst_lockout",   32'(bus.lockout),      32'd0);
        check("rst_fail_cnt",  32'(bus.fail_cnt),     32'd0);
        check("rst_digit_cnt", 32'(bus.digit_cnt),    32'd0);
        check("rst_pass_upd",  32'(bus.pass_updated), 32'd0);

        // Default password opens for exactly 16 cycles.
        press(4'h0); press(4'h0); press(4'h0);
        check("digit_cnt_3", 32'(bus.digit_cnt), 32'd3);
        submit();
        check("open_access", 32'(bus.access),   32'd1);
        check("open_fail",   32'(bus.fail_cnt), 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.access) break;
            n++;
            tick();
        end
        check("open_cycles", 32'(n), 32'd16);

        // Three misses lead to a 64-cycle lockout that ignores strobes.
        press(4'h1); press(4'h2); press(4'h3); submit();
        check("fail_1", 32'(bus.fail_cnt), 32'd1);
        press(4'h1); press(4'h2); press(4'h3); submit();
        check("fail_2", 32'(bus.fail_cnt), 32'd2);
        press(4'h1); press(4'h2); press(4'h3); submit();
        check("lock_lockout", 32'(bus.lockout),  32'd1);
        check("lock_alarm",   32'(bus.alarm),    32'd1);
        check("lock_fail",    32'(bus.fail_cnt), 32'd3);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!bus.lockout) break;
            n++;
            if (i == 3) begin
                bus.digit_valid = 1'b1;
                bus.enter       = 1'b1;
            end
            tick();
            bus.digit_valid = 1'b0;
            bus.enter       = 1'b0;
            if (i == 3) check("lock_ignores_digit", 32'(bus.digit_cnt), 32'd0);
        end
        check("lock_cycles",     32'(n),             32'd64);
        check("post_lock_fail",  32'(bus.fail_cnt),  32'd0);
        check("post_lock_dcnt",  32'(bus.digit_cnt), 32'd0);
`ifdef ALARM_LATCH_EN
        check("post_lock_alarm", 32'(bus.alarm),     32'd1);
`else
        check("post_lock_alarm", 32'(bus.alarm),     32'd0);
`endif

        // Password change in OPEN, early relock, new code opens, old code fails.
        press(4'h0); press(4'h0); press(4'h0); submit();
        check("open2_access", 32'(bus.access), 32'd1);
        bus.set_req  = 1'b1;
        bus.new_pass = 12'h4A7;
        tick();
        bus.set_req  = 1'b0;
        check("pass_upd_pulse",  32'(bus.pass_updated), 32'd1);
        check("set_keeps_open",  32'(bus.access),       32'd1);
        tick();
        check("pass_upd_single", 32'(bus.pass_updated), 32'd0);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        check("early_relock", 32'(bus.access), 32'd0);
        tick();
        press(4'h4); press(4'hA); press(4'h7); submit();
        check("new_pass_open", 32'(bus.access), 32'd1);
        relock();
        press(4'h0); press(4'h0); press(4'h0); submit();
        check("old_pass_access", 32'(bus.access),   32'd0);
        check("old_pass_fail",   32'(bus.fail_cnt), 32'd1);
        bus.set_req  = 1'b1;
        bus.new_pass = 12'h111;
        tick();
        bus.set_req  = 1'b0;
        check("set_idle_no_pulse", 32'(bus.pass_updated), 32'd0);
        press(4'h4); press(4'hA); press(4'h7); submit();
        check("set_idle_ignored", 32'(bus.access),   32'd1);
        check("match_clears_fail", 32'(bus.fail_cnt), 32'd0);
        relock();

        // Short entry fails; surplus digit dropped.
        reset_dut();
        press(4'h0); press(4'h0); submit();
        check("short_access", 32'(bus.access),   32'd0);
        check("short_fail",   32'(bus.fail_cnt), 32'd1);
        press(4'h0); press(4'h0); press(4'h0); press(4'h5);
        check("drop_4th_cnt", 32'(bus.digit_cnt), 32'd3);
        submit();
        check("drop_4th_open", 32'(bus.access), 32'd1);
        relock();

        // Clear beats enter in the same cycle.
        press(4'h1); press(4'h2); press(4'h3); submit();
        check("pre_clear_fail", 32'(bus.fail_cnt), 32'd1);
        press(4'h1);
        check("pre_clear_dcnt", 32'(bus.digit_cnt), 32'd1);
        bus.clear = 1'b1;
        bus.enter = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.enter = 1'b0;
        check("clear_dcnt", 32'(bus.digit_cnt), 32'd0);
        tick();
        check("clear_no_check_fail",    32'(bus.fail_cnt), 32'd1);
        check("clear_no_check_lockout", 32'(bus.lockout),  32'd0);
        press(4'h0); press(4'h0); press(4'h0); submit();
        check("after_clear_open", 32'(bus.access),   32'd1);
        check("after_clear_fail", 32'(bus.fail_cnt), 32'd0);

        // Reset mid-OPEN after a password change restores the default.
        bus.set_req  = 1'b1;
        bus.new_pass = 12'h4A7;
        tick();
        bus.set_req  = 1'b0;
        check("pulse_before_reset", 32'(bus.pass_updated), 32'd1);
        tick(); tick(); tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("reset_mid_open_access", 32'(bus.access), 32'd0);
        check("reset_mid_open_alarm",  32'(bus.alarm),  32'd0);
        press(4'h0); press(4'h0); press(4'h0); submit();
        check("default_restored_open", 32'(bus.access), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
